// File: rtl/rc_check_pkg.sv
// Shared types and helpers for the RC step-response checker.
//   state_t  : run-control state encoding
//   sat_fx   : clamp a wide signed value into a w-bit signed range
//   popcount : number of set bits in a channel fail vector
package rc_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest fail vector popcount can see; channel vectors are zero-extended to this.
    localparam int MAX_CH = 64;

    function automatic longint sat_fx(input longint x, input int unsigned w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fo_model.sv
// First-order recursive reference model for one channel.
//   expt <= sat(expt + ((amp - expt) * ALPHA) >>> ALPHA_FRAC)
// Ports:
//   emu_clk, emu_rst : clock, synchronous active-high reset (expt -> 0)
//   clear            : force expt to 0 at the start of a run
//   update           : advance the model by one sample
//   amp              : signed step target
//   expt             : current expected DUT output
module fo_model #(
    parameter int          WIDTH      = 16,
    parameter int unsigned ALPHA      = 6237,
    parameter int          ALPHA_FRAC = 16
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic                    clear,
    input  logic                    update,
    input  logic signed [WIDTH-1:0] amp,
    output logic signed [WIDTH-1:0] expt
);
    import rc_check_pkg::*;

    // Product width: WIDTH+1 difference times an ALPHA_FRAC+1 signed coefficient.
    localparam int P = WIDTH + 1 + ALPHA_FRAC + 1;
    localparam logic signed [P-1:0] C_ALPHA = P'(ALPHA);

    logic signed [WIDTH-1:0] r_expt;
    logic signed [WIDTH:0]   w_diff;
    logic signed [P-1:0]     w_prod;
    logic signed [P-1:0]     w_step;
    logic signed [P-1:0]     w_sum;

    assign w_diff = (WIDTH+1)'(amp) - (WIDTH+1)'(r_expt);
    assign w_prod = P'(w_diff) * C_ALPHA;
    // Arithmetic shift gives floor rounding for negative steps.
    assign w_step = w_prod >>> ALPHA_FRAC;
    assign w_sum  = P'(r_expt) + w_step;

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_expt <= '0;
        end else if (clear) begin
            r_expt <= '0;
        end else if (update) begin
            r_expt <= WIDTH'(sat_fx(longint'(w_sum), WIDTH));
        end
    end

    assign expt = r_expt;

endmodule

// File: rtl/rc_step_checker.sv
// On-chip step-response stimulus and checker for first-order analog models.
// Drives a latched step on v_in, compares v_out against a per-channel
// recursive model every SAMPLE_CYCLES clocks, and accumulates failures.
// Ports:
//   emu_clk, emu_rst : clock, synchronous active-high reset
//   start, abort     : run launch / cancel pulses (abort wins)
//   amp              : per-channel step amplitude, latched on start
//   v_out            : DUT outputs being checked
//   v_in             : DUT stimulus (amp while running / done, else 0)
//   busy, done, pass : run status; pass valid while done
//   err_count        : saturating total of failed checks
//   err_mask         : sticky per-channel fail flags
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no run; v_in=0, errors from any aborted run still visible
// RUN   | stimulus applied, checks every SAMPLE_CYCLES, then one finish cycle
// DONE  | results frozen, v_in holds amp until start/abort/reset
module rc_step_checker #(
    parameter int          N_CH          = 1,
    parameter int          WIDTH         = 16,
    parameter int unsigned ALPHA         = 6237,
    parameter int          ALPHA_FRAC    = 16,
    parameter int          TOL           = 4,
    parameter int          SAMPLE_CYCLES = 1,
    parameter int          N_SAMPLES     = 25,
    parameter int          ERR_W         = 8
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_CH*WIDTH-1:0]   amp,
    input  logic [N_CH*WIDTH-1:0]   v_out,
    output logic [N_CH*WIDTH-1:0]   v_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
    output logic [N_CH-1:0]         err_mask
);
    import rc_check_pkg::*;

    localparam int          CNT_W   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int          K_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int unsigned ERR_MAX = (32'd1 << ERR_W) - 32'd1;
    localparam logic [WIDTH:0] C_TOL = (WIDTH+1)'(TOL);

    state_t                  r_state;
    logic [N_CH*WIDTH-1:0]   r_v_in;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [ERR_W-1:0]        r_err_count;
    logic [N_CH-1:0]         r_err_mask;
    logic [CNT_W-1:0]        r_cnt;
    logic [K_W-1:0]          r_left;
    logic                    r_last;

    logic                    w_launch;
    logic                    w_check;
    logic [N_CH-1:0]         w_fail;
    logic [31:0]             w_err_sum;
    logic [ERR_W-1:0]        w_err_next;

    assign w_launch = start && !abort && (r_state != RUN);
    // r_last marks the finish cycle after the final check; no check happens there.
    assign w_check  = (r_state == RUN) && !abort && !r_last && (r_cnt == '0);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic signed [WIDTH-1:0] w_expt;
        logic signed [WIDTH:0]   w_diff;
        logic        [WIDTH:0]   w_abs;

        fo_model #(
            .WIDTH      (WIDTH),
            .ALPHA      (ALPHA),
            .ALPHA_FRAC (ALPHA_FRAC)
        ) u_model (
            .emu_clk (emu_clk),
            .emu_rst (emu_rst),
            .clear   (w_launch),
            .update  (w_check),
            .amp     (r_v_in[ch*WIDTH +: WIDTH]),
            .expt    (w_expt)
        );

        // One extra bit keeps the difference and its magnitude exact.
        assign w_diff     = (WIDTH+1)'($signed(v_out[ch*WIDTH +: WIDTH])) - (WIDTH+1)'(w_expt);
        assign w_abs      = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
        assign w_fail[ch] = (w_abs > C_TOL);
    end

    assign w_err_sum  = 32'(r_err_count) + popcount(MAX_CH'(w_fail));
    assign w_err_next = (w_err_sum > ERR_MAX) ? ERR_W'(ERR_MAX) : ERR_W'(w_err_sum);

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_state     <= IDLE;
            r_v_in      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_err_mask  <= '0;
            r_cnt       <= '0;
            r_left      <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_v_in  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (start) begin
                        r_state     <= RUN;
                        r_v_in      <= amp;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_err_mask  <= '0;
                        r_cnt       <= '0;
                        r_left      <= K_W'(N_SAMPLES - 1);
                        r_last      <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_v_in  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == '0);
                        r_last  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_err_count <= w_err_next;
                        r_err_mask  <= r_err_mask | w_fail;
                        r_cnt       <= CNT_W'(SAMPLE_CYCLES - 1);
                        if (r_left == '0) begin
                            r_last <= 1'b1;
                        end else begin
                            r_left <= r_left - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign v_in      = r_v_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign err_mask  = r_err_mask;

endmodule

// File: tb/tb_rc_step_checker.sv
module tb_rc_step_checker;

    localparam int N     = 25;
    localparam int ALPHA = 6237;
    localparam int AF    = 16;
    localparam int TOL   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Three instances: [0] N_CH=1,S=1  [1] N_CH=2,S=3  [2] N_CH=2,S=1,ERR_W=3
    int S_OF[3]    = '{1, 3, 1};
    int NCH_OF[3]  = '{1, 2, 2};
    int EMAX_OF[3] = '{255, 255, 7};

    logic        start_x[3];
    logic        abort_x[3];
    logic        rst_x[3];
    logic [31:0] amp_x[3];
    logic [31:0] vout_x[3];

    logic [31:0] vin_x[3];
    logic        busy_x[3];
    logic        done_x[3];
    logic        pass_x[3];
    logic [7:0]  err_x[3];
    logic [1:0]  mask_x[3];

    logic [15:0] vin0;
    logic [31:0] vin1, vin2;
    logic [7:0]  err0, err1;
    logic [2:0]  err2;
    logic        mask0;
    logic [1:0]  mask1, mask2;

    rc_step_checker #(.N_CH(1), .SAMPLE_CYCLES(1)) u_dut0 (
        .emu_clk(clk), .emu_rst(rst_x[0]), .start(start_x[0]), .abort(abort_x[0]),
        .amp(amp_x[0][15:0]), .v_out(vout_x[0][15:0]), .v_in(vin0),
        .busy(busy_x[0]), .done(done_x[0]), .pass(pass_x[0]),
        .err_count(err0), .err_mask(mask0)
    );

    rc_step_checker #(.N_CH(2), .SAMPLE_CYCLES(3)) u_dut1 (
        .emu_clk(clk), .emu_rst(rst_x[1]), .start(start_x[1]), .abort(abort_x[1]),
        .amp(amp_x[1]), .v_out(vout_x[1]), .v_in(vin1),
        .busy(busy_x[1]), .done(done_x[1]), .pass(pass_x[1]),
        .err_count(err1), .err_mask(mask1)
    );

    rc_step_checker #(.N_CH(2), .SAMPLE_CYCLES(1), .ERR_W(3)) u_dut2 (
        .emu_clk(clk), .emu_rst(rst_x[2]), .start(start_x[2]), .abort(abort_x[2]),
        .amp(amp_x[2]), .v_out(vout_x[2]), .v_in(vin2),
        .busy(busy_x[2]), .done(done_x[2]), .pass(pass_x[2]),
        .err_count(err2), .err_mask(mask2)
    );

    assign vin_x[0]  = {16'h0, vin0};
    assign vin_x[1]  = vin1;
    assign vin_x[2]  = vin2;
    assign err_x[0]  = err0;
    assign err_x[1]  = err1;
    assign err_x[2]  = {5'h0, err2};
    assign mask_x[0] = {1'b0, mask0};
    assign mask_x[1] = mask1;
    assign mask_x[2] = mask2;

    task automatic chk_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    // Expected value at check k: k applications of the first-order recursion from 0.
    function automatic int model_at(input int a, input int k);
        int e;
        e = 0;
        for (int i = 0; i < k; i++) begin
            e = clamp16(longint'(e) + floor_div(longint'(a - e) * ALPHA, longint'(1) << AF));
        end
        return e;
    endfunction

    // mode: 0 = ideal DUT, 1 = output stuck at 0, 2 = ideal plus random +/-6 LSB offset
    task automatic run(input int inst, input int a0, input int a1, input int m0, input int m1,
                       input int abort_at, input int start_at, input int rst_at);
        int          nch, s, emax, errs, nf, v, ex;
        int          a[2];
        int          m[2];
        logic [1:0]  mask;
        logic [31:0] exp_vin;
        bit          cut;
        nch  = NCH_OF[inst];
        s    = S_OF[inst];
        emax = EMAX_OF[inst];
        a[0] = a0; a[1] = a1;
        m[0] = m0; m[1] = m1;
        errs = 0;
        mask = 2'b00;
        cut  = 1'b0;
        exp_vin = (nch == 1) ? {16'h0, 16'(a0)} : {16'(a1), 16'(a0)};

        @(negedge clk);
        amp_x[inst]   = {16'(a1), 16'(a0)};
        start_x[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_x[inst] = 1'b0;
        chk_val("busy_after_start", busy_x[inst], 1);
        chk_val("vin_after_start", vin_x[inst], exp_vin);
        chk_val("err_cleared", err_x[inst], 0);
        chk_val("mask_cleared", mask_x[inst], 0);
        chk_val("done_cleared", done_x[inst], 0);

        for (int k = 0; k < N && !cut; k++) begin
            if (k > 0) begin
                repeat (s - 1) begin
                    @(posedge clk);
                    #1;
                end
            end
            nf = 0;
            for (int c = 0; c < nch; c++) begin
                ex = model_at(a[c], k);
                if (m[c] == 0) v = ex;
                else if (m[c] == 1) v = 0;
                else v = clamp16(longint'(ex) + longint'(int'($urandom_range(12, 0)) - 6));
                vout_x[inst][c*16 +: 16] = 16'(v);
                if (((v - ex) > TOL) || ((ex - v) > TOL)) begin
                    nf++;
                    if (k != abort_at && k != rst_at) mask[c] = 1'b1;
                end
            end
            if (k == abort_at) abort_x[inst] = 1'b1;
            if (k == start_at) start_x[inst] = 1'b1;
            if (k == rst_at)   rst_x[inst]   = 1'b1;
            @(posedge clk);
            #1;
            abort_x[inst] = 1'b0;
            start_x[inst] = 1'b0;
            rst_x[inst]   = 1'b0;

            if (k == abort_at) begin
                chk_val("abort_busy", busy_x[inst], 0);
                chk_val("abort_done", done_x[inst], 0);
                chk_val("abort_vin", vin_x[inst], 0);
                chk_val("abort_err_kept", err_x[inst], errs);
                chk_val("abort_mask_kept", mask_x[inst], mask);
                cut = 1'b1;
            end else if (k == rst_at) begin
                chk_val("rst_busy", busy_x[inst], 0);
                chk_val("rst_done", done_x[inst], 0);
                chk_val("rst_pass", pass_x[inst], 0);
                chk_val("rst_vin", vin_x[inst], 0);
                chk_val("rst_err", err_x[inst], 0);
                chk_val("rst_mask", mask_x[inst], 0);
                cut = 1'b1;
            end else begin
                errs = (errs + nf > emax) ? emax : errs + nf;
                if (k == 12) chk_val("err_midrun", err_x[inst], errs);
            end
        end

        if (!cut) begin
            chk_val("done_low_before_finish", done_x[inst], 0);
            chk_val("busy_high_before_finish", busy_x[inst], 1);
            @(posedge clk);
            #1;
            chk_val("done_rise", done_x[inst], 1);
            chk_val("busy_fall", busy_x[inst], 0);
            chk_val("err_final", err_x[inst], errs);
            chk_val("mask_final", mask_x[inst], mask);
            chk_val("pass_final", pass_x[inst], (errs == 0) ? 1 : 0);
            chk_val("vin_hold", vin_x[inst], exp_vin);
            repeat (3) @(posedge clk);
            #1;
            chk_val("done_stable", done_x[inst], 1);
            chk_val("err_stable", err_x[inst], errs);
        end
    endtask

    task automatic abort_from_done(input int inst, input int exp_err);
        @(negedge clk);
        abort_x[inst] = 1'b1;
        @(posedge clk);
        #1;
        abort_x[inst] = 1'b0;
        chk_val("done_abort_done", done_x[inst], 0);
        chk_val("done_abort_vin", vin_x[inst], 0);
        chk_val("done_abort_err_kept", err_x[inst], exp_err);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_x[i] = 1'b0;
            abort_x[i] = 1'b0;
            rst_x[i]   = 1'b1;
            amp_x[i]   = '0;
            vout_x[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_x[i] = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_val("reset_busy", busy_x[i], 0);
            chk_val("reset_done", done_x[i], 0);
            chk_val("reset_pass", pass_x[i], 0);
            chk_val("reset_err", err_x[i], 0);
            chk_val("reset_mask", mask_x[i], 0);
            chk_val("reset_vin", vin_x[i], 0);
        end

        run(0, 4096, 0, 0, 0, -1, -1, -1);       // ideal single channel
        run(0, 4096, 0, 1, 0, -1, -1, -1);       // stuck output: 24 failures
        abort_from_done(0, 24);
        run(1, 4096, -2048, 1, 0, -1, -1, -1);   // two channels, SAMPLE_CYCLES=3
        run(0, 4096, 0, 1, 0, 10, -1, -1);       // abort at check 10
        run(0, 4096, 0, 0, 0, -1, -1, -1);       // clean rerun after abort
        run(0, -3000, 0, 0, 0, -1, 7, -1);       // start pulsed mid-run is ignored
        run(0, 4096, 0, 1, 0, -1, -1, 5);        // reset at check 5
        run(2, 4096, 4096, 1, 1, -1, -1, -1);    // error counter saturates at 7

        for (int i = 0; i < 8; i++) begin
            int inst;
            int ra0, ra1;
            inst = i % 2;
            ra0  = int'($urandom_range(65535, 0)) - 32768;
            ra1  = int'($urandom_range(65535, 0)) - 32768;
            run(inst, ra0, ra1, 2, (i % 4 == 1) ? 0 : 2, -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rc_step_checker.md
# rc_step_checker

Synthesizable, parametrised step-response stimulus and checker for first-order analog models running in the emulator. It drives up to N_CH fixed-point step inputs into the DUT and samples the DUT outputs every SAMPLE_CYCLES emulator clocks. Each sample is compared against an on-chip recursive first-order reference model within a tolerance. It replaces the testbench-only RC checker so that regression runs on FPGA without a host in the loop, and sits between the emulator control logic and the analog model under test.

## Interface
- N_CH, 1: number of independent channels
- WIDTH, 16: signed fixed-point width of stimulus/response words
- ALPHA, 6237: model coefficient, 1-exp(-SAMPLE_CYCLES*dt/tau), unsigned, ALPHA_FRAC fractional bits
- ALPHA_FRAC, 16: fractional bits of ALPHA (ALPHA < 2^ALPHA_FRAC)
- TOL, 4: absolute tolerance in LSBs of WIDTH
- SAMPLE_CYCLES, 1: emu_clk cycles between checks (>=1)
- N_SAMPLES, 25: checks per run (>=1)
- ERR_W, 8: error counter width

Ports:
- emu_clk  in  1  emulator clock
- emu_rst  in  1  synchronous active-high reset
- start  in  1  launch run (pulse)
- abort  in  1  cancel run (pulse)
- amp  in  N_CH*WIDTH  per-channel signed step amplitude, latched on start
- v_out  in  N_CH*WIDTH  DUT outputs, signed
- v_in  out  N_CH*WIDTH  DUT stimulus, signed
- busy  out  1  run in progress
- done  out  1  run completed (level)
- pass  out  1  valid while done; 1 iff err_count==0
- err_count  out  ERR_W  total failed checks, all channels, saturating
- err_mask  out  N_CH  sticky per-channel fail flag

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state IDLE; v_in=0, busy=0, done=0, pass=0, err_count=0, err_mask=0; model states 0.
- IDLE/DONE + start:
  - latch amp into v_in.
  - clear err_count, err_mask and done; model states = 0.
  - sample index k=0, cycle counter = 0.
  - go to RUN.
- RUN: on each check edge, for every channel:
  - compare v_out against the model value expt[k];
  - if |v_out - expt| > TOL, set err_mask[ch].
  - err_count increases by the number of failing channels that edge, saturating at 2^ERR_W-1.
  - Then update the model: expt <= expt + (((amp - expt) * ALPHA) >>> ALPHA_FRAC).
  - Operands are sign-extended to WIDTH+1 for the difference and WIDTH+1+ALPHA_FRAC+1 for the product.
  - The shift is arithmetic (floor).
  - Result saturates to the WIDTH range.
  - The difference for the tolerance check uses WIDTH+1 bits; no overflow.
- After check k=N_SAMPLES-1: go to DONE; done=1, busy=0, pass=(err_count==0).
- DONE: v_in holds amp; outputs stable until start, abort or reset.
- abort in RUN or DONE: IDLE next edge; v_in=0, busy=0, done=0; err_count/err_mask retained.
- start while RUN: ignored.
- start and abort on the same edge: abort wins.

## Timing
- start seen at edge t0: v_in=amp and busy=1 after t0.
- Check k occurs at edge t0 + 1 + k*SAMPLE_CYCLES, sampling v_out registered at that edge.
- done rises one edge after the last check: t0 + 2 + (N_SAMPLES-1)*SAMPLE_CYCLES.
- Model update is single-cycle; no pipelining. The check at k uses expt from the update at k-1.
- err_count/err_mask update on the check edge and are visible the cycle after.
- emu_rst mid-run: all outputs return to reset values on that edge; the run is lost.

## Structure
- Package rc_check_pkg:
  - state enum (IDLE, RUN, DONE);
  - fixed-point saturate function;
  - popcount function used for err_count increments.
- Sub-module fo_model: one per channel (generate loop). It holds expt and performs the update/saturation. Ports:
  - emu_clk, emu_rst;
  - clear, update, amp;
  - expt.
- Top holds the FSM, cycle/sample counters, compare and error accounting.

## Test plan
- Ideal DUT: bench runs the same recursion; N_CH=1, amp=4096 (1.0 at 12 frac bits), SAMPLE_CYCLES=1 -> 25 checks, done at t0+26, pass=1, err_count=0.
- Stuck output: v_out=0, amp=4096, TOL=4 -> check 0 passes, expt[1]=389 fails. Final err_count=24, err_mask=1, pass=0.
- Two channels: ch0 stuck at 0, ch1 ideal with amp=-2048, SAMPLE_CYCLES=3 -> err_mask=2'b01, err_count=24, done at t0+74.
- Abort at check 10:
  - next edge: busy=0, done=0, v_in=0, err_count retained.
  - a new start clears err_count and reruns cleanly.
- Start pulsed during RUN has no effect on k. emu_rst asserted at check 5 -> all outputs 0 next edge.
- ERR_W=3, N_CH=2, both channels stuck -> err_count saturates at 7, pass=0.
